pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on PwmIn (legal range 2..4).
REQ-002 SHALL have parameter MAX_PERIOD, default 4095, period count in Clk cycles at which a timeout is declared (legal range 16..4095).
REQ-003 SHALL have port Clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port PwmIn, input, 1, asynchronous PWM waveform to be demodulated.
REQ-006 SHALL have port SigVec, output, 11, measured high time of the last complete PWM period, in Clk cycles.
REQ-007 SHALL have port Period, output, 12, measured length of the last complete PWM period, in Clk cycles.
REQ-008 SHALL have port SigValid, output, 1, one-cycle strobe: SigVec and Period updated this cycle.
REQ-009 SHALL have port Timeout, output, 1, one-cycle strobe: no rising edge seen within MAX_PERIOD cycles.
REQ-010 SHALL have port Locked, output, 1, level: high while in state MEASURE.

Function
REQ-011 SHALL pass PwmIn through SYNC_STAGES flops; the last stage output is the synchronized level s.
REQ-012 SHALL register s into s_d; rise = s AND NOT s_d; only rise delimits periods.
REQ-013 SHALL implement states IDLE and MEASURE.
REQ-014 In IDLE: counters held at 0, no SigValid; on rise, go to MEASURE and load period_cnt=1 and high_cnt=1.
REQ-015 In MEASURE, with no rise: period_cnt increments by 1 each cycle; high_cnt increments by 1 when s=1, saturating at 2047.
REQ-016 In MEASURE, on rise: SigVec<=high_cnt, Period<=period_cnt, SigValid=1 in the next cycle; period_cnt<=1 and high_cnt<=1 in the same cycle (no dead cycle between periods).
REQ-017 In MEASURE, when period_cnt equals MAX_PERIOD and there is no rise: Timeout=1 and SigValid=1 in the next cycle; SigVec<=2047 if s=1, else 0; Period<=MAX_PERIOD; go to IDLE.
REQ-018 Rise coincident with period_cnt==MAX_PERIOD SHALL be treated as a normal rise (REQ-016), with no timeout.
REQ-019 Latency: a PwmIn rising edge sampled at cycle n SHALL produce SigValid at cycle n+SYNC_STAGES+2.
REQ-020 SigVec and Period SHALL hold their values between strobes.
REQ-021 SigValid and Timeout SHALL be high for exactly one cycle per event.
REQ-022 A high time of 2048 or more SHALL be reported as SigVec=2047 (saturation, no wrap).
REQ-023 A period of 1 cycle cannot occur (rise needs a low sample); the minimum reported Period SHALL be 2.
REQ-024 Locked SHALL be 1 in MEASURE and 0 in IDLE.

Reset
REQ-025 With Rst=1 at a clock edge, the block SHALL clear all synchronizer flops, s_d, period_cnt and high_cnt to 0.
REQ-026 With Rst=1 at a clock edge, SigVec=0, Period=0, SigValid=0, Timeout=0, Locked=0, and state=IDLE.
REQ-027 Rst asserted mid-period SHALL discard the partial measurement; no strobe SHALL be issued for it.
REQ-028 After Rst is released, the first SigValid SHALL require two rises (the first rise only enters MEASURE).

Verification
REQ-029 Stimulus: Rst 4 cycles, then a PWM with period 2048 and high 512 cycles, repeated 3 times. Required: first strobe after the 2nd rise; every strobe gives SigVec=512, Period=2048, Locked=1.
REQ-030 Stimulus: PWM with period 2048 and high 2047 (one low cycle). Required: SigVec=2047, Period=2048.
REQ-031 Stimulus: lock the block, then hold PwmIn=0. Required: Timeout and SigValid pulse together with SigVec=0 and Period=4095; then Locked=0 and no further strobes.
REQ-032 Stimulus: lock the block, then hold PwmIn=1 for 5000 cycles. Required: Timeout with SigVec=2047; the next rise re-locks the block without a strobe.
REQ-033 Stimulus: assert Rst for 1 cycle mid-period. Required: all outputs are 0 the next cycle, and no strobe for the interrupted period.
REQ-034 Stimulus: a single rise at cycle n. Required: Locked rises at cycle n+SYNC_STAGES+2; measure the strobe latency on the next rise against REQ-019.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM demodulator: synchronizes PwmIn, measures high time and period between rising edges,
// and flags a timeout when no rising edge arrives within MAX_PERIOD cycles.
module pwm_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_PERIOD  = 4095
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PwmIn,
  output logic [10:0] SigVec,
  output logic [11:0] Period,
  output logic        SigValid,
  output logic        Timeout,
  output logic        Locked
);

  localparam int unsigned HW = 11;
  localparam int unsigned PW = 12;
  localparam logic [HW-1:0] HIGH_SAT = '1;
  localparam logic [PW-1:0] PER_MAX  = PW'(MAX_PERIOD);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_s_d;
  logic                   r_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PW-1:0]          r_period_cnt;
  logic [PW-1:0]          w_period_cnt_nxt;
  logic [HW-1:0]          r_high_cnt;
  logic [HW-1:0]          w_high_cnt_nxt;
  logic [HW-1:0]          w_sigvec_nxt;
  logic [PW-1:0]          w_period_nxt;
  logic                   w_valid_nxt;
  logic                   w_timeout_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchronizer, edge detector; rise is registered so r_s_d is the level aligned with r_rise.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PwmIn};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
    end
  end

  // State and measurement registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      SigVec       <= '0;
      Period       <= '0;
      SigValid     <= 1'b0;
      Timeout      <= 1'b0;
      Locked       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_high_cnt   <= w_high_cnt_nxt;
      SigVec       <= w_sigvec_nxt;
      Period       <= w_period_nxt;
      SigValid     <= w_valid_nxt;
      Timeout      <= w_timeout_nxt;
      Locked       <= (w_state_nxt == MEASURE);
    end
  end

  // Next-state and measurement update; a rise wins over a coincident timeout.
  always_comb begin
    w_state_nxt      = r_state;
    w_period_cnt_nxt = r_period_cnt;
    w_high_cnt_nxt   = r_high_cnt;
    w_sigvec_nxt     = SigVec;
    w_period_nxt     = Period;
    w_valid_nxt      = 1'b0;
    w_timeout_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_period_cnt_nxt = '0;
        w_high_cnt_nxt   = '0;
        if (r_rise) begin
          w_state_nxt      = MEASURE;
          w_period_cnt_nxt = PW'(1);
          w_high_cnt_nxt   = HW'(1);
        end
      end
      MEASURE: begin
        if (r_rise) begin
          w_sigvec_nxt     = r_high_cnt;
          w_period_nxt     = r_period_cnt;
          w_valid_nxt      = 1'b1;
          w_period_cnt_nxt = PW'(1);
          w_high_cnt_nxt   = HW'(1);
        end else if (r_period_cnt == PER_MAX) begin
          w_sigvec_nxt     = r_s_d ? HIGH_SAT : '0;
          w_period_nxt     = PER_MAX;
          w_valid_nxt      = 1'b1;
          w_timeout_nxt    = 1'b1;
          w_state_nxt      = IDLE;
          w_period_cnt_nxt = '0;
          w_high_cnt_nxt   = '0;
        end else begin
          w_period_cnt_nxt = r_period_cnt + PW'(1);
          if (r_s_d && (r_high_cnt != HIGH_SAT)) begin
            w_high_cnt_nxt = r_high_cnt + HW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected strobes are queued before the closing rise is driven
// and checked by a negedge monitor when SigValid fires.
module tb_pwm_capture;

  localparam int unsigned SYNC = 2;
  localparam int unsigned MAXP = 4095;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        PwmIn = 1'b0;
  logic [10:0] SigVec;
  logic [11:0] Period;
  logic        SigValid;
  logic        Timeout;
  logic        Locked;

  typedef struct packed {
    logic [10:0] sv;
    logic [11:0] per;
    logic        to;
    logic        lk;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   n0;
  int   m0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  pwm_capture #(.SYNC_STAGES(SYNC), .MAX_PERIOD(MAXP)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .PwmIn    (PwmIn),
    .SigVec   (SigVec),
    .Period   (Period),
    .SigValid (SigValid),
    .Timeout  (Timeout),
    .Locked   (Locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(negedge Clk);
      PwmIn = v;
    end
  endtask

  task automatic pwm(input int high, input int per);
    hold(1'b1, high);
    hold(1'b0, per - high);
  endtask

  task automatic push(input int sv, input int per, input logic to, input logic lk);
    exp_t e;
    e.sv  = 11'(sv);
    e.per = 12'(per);
    e.to  = to;
    e.lk  = lk;
    q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sigvec"}, 32'(SigVec), 32'd0);
    check({tag, "_period"}, 32'(Period), 32'd0);
    check({tag, "_valid"}, 32'(SigValid), 32'd0);
    check({tag, "_timeout"}, 32'(Timeout), 32'd0);
    check({tag, "_locked"}, 32'(Locked), 32'd0);
  endtask

  initial begin
    fork
      // Strobe monitor
      forever begin
        exp_t e;
        @(negedge Clk);
        if (SigValid) begin
          check("strobe_pending", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("sigvec", 32'(SigVec), 32'(e.sv));
            check("period", 32'(Period), 32'(e.per));
            check("timeout", 32'(Timeout), 32'(e.to));
            check("locked", 32'(Locked), 32'(e.lk));
          end
        end
        if (Timeout) check("timeout_has_valid", 32'(SigValid), 32'd1);
      end
    join_none

    // Reset for 4 cycles
    Rst   = 1'b1;
    PwmIn = 1'b0;
    repeat (4) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;

    // 2048/512 PWM x3: strobes only from the 2nd rise on
    pwm(512, 2048);
    push(512, 2048, 1'b0, 1'b1);
    pwm(512, 2048);
    push(512, 2048, 1'b0, 1'b1);
    pwm(512, 2048);
    wait_drain(20);
    check("locked_after_pwm", 32'(Locked), 32'd1);

    // One low cycle per period, then a short high pulse and a stuck-low line
    push(512, 2048, 1'b0, 1'b1);
    pwm(2047, 2048);
    push(2047, 2048, 1'b0, 1'b1);
    push(0, MAXP, 1'b1, 1'b0);
    hold(1'b1, 1);
    hold(1'b0, 4200);
    wait_drain(20);
    check("unlocked_after_low_timeout", 32'(Locked), 32'd0);
    hold(1'b0, 300);
    check("no_strobe_after_timeout", 32'(q.size()), 32'd0);
    check("still_unlocked", 32'(Locked), 32'd0);

    // Lock latency from IDLE, then strobe latency on the next rise
    @(negedge Clk);
    PwmIn = 1'b1;
    n0 = cyc;
    for (int i = 1; i < 20; i++) begin
      @(negedge Clk);
      PwmIn = (i < 7);
      if (cyc == n0 + int'(SYNC) + 1) check("locked_pre", 32'(Locked), 32'd0);
      if (cyc == n0 + int'(SYNC) + 2) check("locked_rise", 32'(Locked), 32'd1);
    end
    push(7, 20, 1'b0, 1'b1);
    push(2047, MAXP, 1'b1, 1'b0);
    @(negedge Clk);
    PwmIn = 1'b1;
    m0 = cyc;
    // Hold high past the timeout
    for (int i = 1; i < 5000; i++) begin
      @(negedge Clk);
      PwmIn = 1'b1;
      if (cyc == m0 + int'(SYNC) + 1) check("latency_pre", 32'(SigValid), 32'd0);
      if (cyc == m0 + int'(SYNC) + 2) check("latency_strobe", 32'(SigValid), 32'd1);
    end
    wait_drain(20);
    check("unlocked_after_high_timeout", 32'(Locked), 32'd0);

    // Re-lock without a strobe
    hold(1'b0, 10);
    hold(1'b1, 6);
    check("relocked", 32'(Locked), 32'd1);
    hold(1'b0, 10);

    // One-cycle reset in the low phase of an open period
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check_all_zero("midreset");
    hold(1'b0, 20);
    pwm(30, 100);
    push(30, 100, 1'b0, 1'b1);
    pwm(30, 100);
    wait_drain(20);
    check("locked_after_reset_pwm", 32'(Locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge Clk);
    $display("FAIL watchdog: cycle budget exhausted, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
